// File: rtl/reconf_tile_seq_if.sv
// Command, operand, tile and result signals shared between the front end,
// the tile sequencer and the tile.
interface reconf_tile_seq_if #(
    parameter int TILE_SIZE = 128,
    parameter int DW        = 16,
    parameter int LEN_W     = 8
);
    logic                    cmd_valid_i;
    logic                    cmd_ready_o;
    logic [1:0]              cmd_op_i;
    logic [LEN_W-1:0]        cmd_len_i;
    logic [DW-1:0]           cmd_scal_i;
    logic                    op_valid_i;
    logic                    op_ready_o;
    logic                    tile_control_o;
    logic [DW-1:0]           tile_scal_o;
    logic [DW-1:0]           tile_o_scal_i;
    logic [TILE_SIZE*DW-1:0] tile_o_vec_i;
    logic                    res_vec_valid_o;
    logic                    res_vec_ready_i;
    logic [TILE_SIZE*DW-1:0] res_vec_o;
    logic                    res_scal_valid_o;
    logic                    res_scal_ready_i;
    logic [DW-1:0]           res_scal_o;
    logic                    busy_o;
    logic                    done_o;

    // Sequencer side.
    modport slave (
        input  cmd_valid_i, cmd_op_i, cmd_len_i, cmd_scal_i, op_valid_i,
               tile_o_scal_i, tile_o_vec_i, res_vec_ready_i, res_scal_ready_i,
        output cmd_ready_o, op_ready_o, tile_control_o, tile_scal_o,
               res_vec_valid_o, res_vec_o, res_scal_valid_o, res_scal_o,
               busy_o, done_o
    );

    // Front end / tile / result consumer side.
    modport master (
        output cmd_valid_i, cmd_op_i, cmd_len_i, cmd_scal_i, op_valid_i,
               tile_o_scal_i, tile_o_vec_i, res_vec_ready_i, res_scal_ready_i,
        input  cmd_ready_o, op_ready_o, tile_control_o, tile_scal_o,
               res_vec_valid_o, res_vec_o, res_scal_valid_o, res_scal_o,
               busy_o, done_o
    );
endinterface

// File: rtl/reconf_tile_seq.sv
// Command sequencer for the 128-lane fp16 tile: issues operand chunks,
// accumulates dot-product partial sums and buffers vector results.
//
// state | meaning
// IDLE  | waiting for a command
// RUN   | issuing operand chunks to the tile
// DRAIN | all chunks issued, waiting for results to return / leave the FIFO
// DONE  | dot result held on res_scal until it is taken

// Combinational fp16 adder, round-to-nearest-even, IEEE specials.
module fp16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic        a_nan, b_nan, a_inf, b_inf, swap, sticky, round_up;
    logic [15:0] big, sml;
    logic [4:0]  e_b, e_s, d, lim;
    logic [10:0] m_b, m_s;
    logic [13:0] ms_x, ms_sh, n;
    logic [14:0] sum;
    logic [3:0]  lz, sh;
    logic [6:0]  e_n, e_r;
    logic [11:0] m_r;

    // Align, add/subtract, normalise and round in one pass.
    always_comb begin
        a_nan  = (&a[14:10]) && (|a[9:0]);
        b_nan  = (&b[14:10]) && (|b[9:0]);
        a_inf  = (&a[14:10]) && !(|a[9:0]);
        b_inf  = (&b[14:10]) && !(|b[9:0]);
        swap   = b[14:0] > a[14:0];
        big    = swap ? b : a;
        sml    = swap ? a : b;
        e_b    = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
        e_s    = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
        m_b    = {big[14:10] != 5'd0, big[9:0]};
        m_s    = {sml[14:10] != 5'd0, sml[9:0]};
        d      = e_b - e_s;
        ms_x   = {m_s, 3'b000};
        ms_sh  = '0;
        sticky = 1'b0;
        if (d >= 5'd14) begin
            sticky = |m_s;
        end else begin
            ms_sh  = ms_x >> d;
            sticky = |(ms_x & ((14'd1 << d) - 14'd1));
        end
        ms_sh[0] = ms_sh[0] | sticky;
        if (big[15] == sml[15]) sum = {1'b0, m_b, 3'b000} + {1'b0, ms_sh};
        else                    sum = {1'b0, m_b, 3'b000} - {1'b0, ms_sh};
        lz = 4'd14;
        for (int i = 0; i < 14; i++) begin
            if (sum[i]) lz = 4'(13 - i);
        end
        // Left shift is capped so the exponent never drops below 1;
        // anything still unnormalised is then a subnormal.
        lim = e_b - 5'd1;
        sh  = '0;
        if (sum[14]) begin
            n    = sum[14:1];
            n[0] = sum[1] | sum[0];
            e_n  = {2'b00, e_b} + 7'd1;
        end else begin
            if ({1'b0, lz} < lim) sh = lz;
            else                  sh = lim[3:0];
            n   = sum[13:0] << sh;
            e_n = {2'b00, e_b} - {3'b000, sh};
        end
        round_up = n[2] & (n[1] | n[0] | n[3]);
        m_r      = {1'b0, n[13:3]} + {11'd0, round_up};
        e_r      = e_n;
        if (m_r[11]) begin
            m_r = m_r >> 1;
            e_r = e_n + 7'd1;
        end
        if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15])))
            y = 16'h7E00;
        else if (a_inf || b_inf)
            y = a_inf ? a : b;
        else if (sum == 15'd0)
            y = {big[15] & sml[15], 15'd0};
        else if (!m_r[10])
            y = {big[15], 5'd0, m_r[9:0]};
        else if (e_r >= 7'd31)
            y = {big[15], 5'h1F, 10'd0};
        else
            y = {big[15], e_r[4:0], m_r[9:0]};
    end
endmodule

module reconf_tile_seq #(
    parameter int TILE_SIZE = 128,
    parameter int DW        = 16,
    parameter int LEN_W     = 8,
    parameter int TILE_LAT  = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    reconf_tile_seq_if.slave  bus
);
    localparam int FIFO_D = TILE_LAT + 1;
    localparam int PTR_W  = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int CNT_W  = $clog2(FIFO_D + 1);
    localparam int VW     = TILE_SIZE * DW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       op_q;
    logic [LEN_W-1:0] len_q, issued_q, returned_q, returned_inc, inflight;
    logic [DW-1:0]    scal_q, acc_q, acc_sum;
    logic             ctrl_q, done_q, done_d;
    logic             is_dot, cmd_ready, cmd_acc, op_ready, issue, issue_first;
    logic             ret_valid, ret_first, all_ret_nxt, credit_ok;
    logic [VW-1:0]    fifo_mem [FIFO_D];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             push, pop, vec_valid;

    assign is_dot       = (op_q == 2'd0);
    assign cmd_ready    = (state_q == S_IDLE) && !done_q;
    assign cmd_acc      = bus.cmd_valid_i && cmd_ready;
    assign inflight     = issued_q - returned_q;
    assign credit_ok    = (32'(fifo_cnt) + 32'(inflight)) < 32'(FIFO_D);
    assign op_ready     = (state_q == S_RUN) && (is_dot || credit_ok);
    assign issue        = bus.op_valid_i && op_ready;
    assign issue_first  = (issued_q == '0);
    assign returned_inc = returned_q + LEN_W'(ret_valid);
    assign all_ret_nxt  = (returned_inc == len_q);
    assign vec_valid    = (fifo_cnt != '0);
    assign push         = ret_valid && !is_dot;
    assign pop          = vec_valid && bus.res_vec_ready_i;

    // Tag delay line: a tag leaves it in the cycle its result is on tile_o_*.
    if (TILE_LAT == 0) begin : g_nolat
        assign ret_valid = issue;
        assign ret_first = issue_first;
    end else begin : g_lat
        logic [TILE_LAT-1:0] dl_valid, dl_first;

        // Shift issued-chunk tags along with the tile pipeline.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                dl_valid <= '0;
                dl_first <= '0;
            end else begin
                dl_valid[0] <= issue;
                dl_first[0] <= issue && issue_first;
                for (int i = 1; i < TILE_LAT; i++) begin
                    dl_valid[i] <= dl_valid[i-1];
                    dl_first[i] <= dl_first[i-1];
                end
            end
        end

        assign ret_valid = dl_valid[TILE_LAT-1];
        assign ret_first = dl_first[TILE_LAT-1];
    end

    fp16_add u_add (
        .a (acc_q),
        .b (bus.tile_o_scal_i),
        .y (acc_sum)
    );

    // Next-state and completion pulse.
    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_acc) begin
                    if (bus.cmd_len_i != '0)       state_d = S_RUN;
                    else if (bus.cmd_op_i == 2'd0) state_d = S_DONE;
                    else                           done_d  = 1'b1;
                end
            end
            S_RUN: begin
                // With no tile latency the last dot chunk returns as it issues.
                if (issue && (issued_q == len_q - LEN_W'(1))) begin
                    if (is_dot && all_ret_nxt) state_d = S_DONE;
                    else                       state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (is_dot) begin
                    if (all_ret_nxt) state_d = S_DONE;
                end else if ((returned_q == len_q) && (fifo_cnt == '0)) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DONE: begin
                if (bus.res_scal_ready_i) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, command registers, counters and dot accumulator.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            done_q     <= 1'b0;
            op_q       <= '0;
            len_q      <= '0;
            scal_q     <= '0;
            ctrl_q     <= 1'b0;
            issued_q   <= '0;
            returned_q <= '0;
            acc_q      <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (cmd_acc) begin
                op_q       <= bus.cmd_op_i;
                len_q      <= bus.cmd_len_i;
                scal_q     <= bus.cmd_scal_i;
                ctrl_q     <= (bus.cmd_op_i == 2'd2);
                issued_q   <= '0;
                returned_q <= '0;
                if ((bus.cmd_len_i == '0) && (bus.cmd_op_i == 2'd0)) acc_q <= '0;
            end else begin
                if (issue)     issued_q   <= issued_q + LEN_W'(1);
                if (ret_valid) returned_q <= returned_inc;
                if (ret_valid && is_dot) acc_q <= ret_first ? bus.tile_o_scal_i : acc_sum;
            end
        end
    end

    // Vector FIFO pointers and occupancy.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_D - 1)) ? '0 : wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_D - 1)) ? '0 : rd_ptr + PTR_W'(1);
            if (push && !pop)      fifo_cnt <= fifo_cnt + CNT_W'(1);
            else if (pop && !push) fifo_cnt <= fifo_cnt - CNT_W'(1);
        end
    end

    // Vector FIFO storage; contents are only visible while the count is non-zero.
    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr] <= bus.tile_o_vec_i;
    end

    assign bus.cmd_ready_o      = cmd_ready;
    assign bus.op_ready_o       = op_ready;
    assign bus.tile_control_o   = ctrl_q;
    assign bus.tile_scal_o      = scal_q;
    assign bus.res_vec_valid_o  = vec_valid;
    assign bus.res_vec_o        = vec_valid ? fifo_mem[rd_ptr] : '0;
    assign bus.res_scal_valid_o = (state_q == S_DONE);
    assign bus.res_scal_o       = acc_q;
    assign bus.busy_o           = (state_q != S_IDLE);
    assign bus.done_o           = done_q;
endmodule

// File: tb/tb_reconf_tile_seq.sv
// Bench for reconf_tile_seq: a command table run on a TILE_LAT=2 instance
// with a result scoreboard, plus reset and TILE_LAT=0 sequences.
module tb_reconf_tile_seq;
    localparam int TS  = 128;
    localparam int DW  = 16;
    localparam int LW  = 8;
    localparam int LAT = 2;
    localparam int VW  = TS * DW;

    typedef struct {
        logic [1:0]  op;
        int          len;
        logic [15:0] scal;
        logic [15:0] v0;
        logic [15:0] vn;
        int          vstep;
        bit          bubble;
        int          hold;
        logic [15:0] exp_scal;
        int          exp_hold_iss;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;
    vec_t tbl [12];

    logic [15:0] tile_now;
    logic [15:0] tile_now0;
    logic [15:0] pipe [LAT];

    reconf_tile_seq_if #(.TILE_SIZE(TS), .DW(DW), .LEN_W(LW)) bif ();
    reconf_tile_seq_if #(.TILE_SIZE(TS), .DW(DW), .LEN_W(LW)) bif0 ();

    reconf_tile_seq #(.TILE_SIZE(TS), .DW(DW), .LEN_W(LW), .TILE_LAT(LAT)) u_dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif)
    );

    reconf_tile_seq #(.TILE_SIZE(TS), .DW(DW), .LEN_W(LW), .TILE_LAT(0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bif0)
    );

    always #5 clk = ~clk;

    // Tile model: whatever the operands produce appears LAT cycles later.
    always @(posedge clk) begin
        pipe[0] <= tile_now;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bif.tile_o_scal_i  = pipe[LAT-1];
    assign bif.tile_o_vec_i   = {TS{pipe[LAT-1]}};
    assign bif0.tile_o_scal_i = tile_now0;
    assign bif0.tile_o_vec_i  = {TS{tile_now0}};

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got lane0 %0h expected lane0 %0h", nm, got[15:0], exp[15:0]);
        end
    endtask

    task automatic run_cmd(input vec_t v);
        logic [VW-1:0] vq [$];
        logic [VW-1:0] e;
        int  issued = 0, cyc = 0, hold_iss = 0, first_iss = -1, last_iss = -1;
        int  scal_vld = -1, vec_vld = -1, hs_cyc = -1, done_cyc = -1, n_done = 0, n_vec = 0;
        bit  is_dot;
        is_dot = (v.op == 2'd0);
        for (int k = 0; k < 20 && bif.cmd_ready_o !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        bif.cmd_valid_i = 1'b1;
        bif.cmd_op_i    = v.op;
        bif.cmd_len_i   = 8'(v.len);
        bif.cmd_scal_i  = v.scal;
        @(negedge clk);
        chk("cmd_ready_idle", bif.cmd_ready_o, 1);
        @(posedge clk); #1;
        bif.cmd_valid_i = 1'b0;
        while (cyc < 300 && n_done == 0) begin
            if (issued < v.len && (!v.bubble || cyc % 2 == 0)) begin
                bif.op_valid_i = 1'b1;
                if (issued == 0)  tile_now = v.v0;
                else if (is_dot)  tile_now = v.vn;
                else              tile_now = v.v0 + 16'(issued * v.vstep);
            end else begin
                bif.op_valid_i = 1'b0;
                tile_now       = 16'hDEAD;
            end
            bif.res_vec_ready_i  = (cyc >= v.hold);
            bif.res_scal_ready_i = (cyc >= v.hold);
            @(negedge clk);
            if (cyc == 0) begin
                chk("tile_control", bif.tile_control_o, (v.op == 2'd2));
                chk("tile_scal", bif.tile_scal_o, v.scal);
                chk("busy", bif.busy_o, !(v.len == 0 && !is_dot));
            end
            if (bif.op_valid_i && bif.op_ready_o) begin
                if (!is_dot) vq.push_back({TS{tile_now}});
                if (cyc < v.hold) hold_iss++;
                if (first_iss < 0) first_iss = cyc;
                last_iss = cyc;
                issued++;
            end
            if (bif.res_vec_valid_o && vec_vld < 0) vec_vld = cyc;
            if (bif.res_vec_valid_o && bif.res_vec_ready_i) begin
                n_vec++;
                if (vq.size() == 0) chk("vec_unexpected", n_vec, 0);
                else begin
                    e = vq.pop_front();
                    chk_vec("vec_result", bif.res_vec_o, e);
                end
            end
            if (bif.res_scal_valid_o && scal_vld < 0) scal_vld = cyc;
            if (bif.res_scal_valid_o && bif.res_scal_ready_i) begin
                chk("scal_result", bif.res_scal_o, v.exp_scal);
                hs_cyc = cyc;
            end
            if (bif.done_o) begin
                n_done++;
                done_cyc = cyc;
                chk("no_accept_on_done", bif.cmd_ready_o, 0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bif.op_valid_i = 1'b0;
        tile_now       = 16'hDEAD;
        chk("done_count", n_done, 1);
        chk("issued", issued, v.len);
        chk("vec_count", n_vec, is_dot ? 0 : v.len);
        if (is_dot) begin
            chk("scal_vld_time", scal_vld, (v.len == 0) ? 0 : last_iss + LAT + 1);
            chk("done_after_hs", done_cyc, hs_cyc + 1);
        end else if (v.len == 0) begin
            chk("len0_done_time", done_cyc, 0);
        end else begin
            chk("vec_vld_time", vec_vld, first_iss + LAT + 1);
        end
        if (v.exp_hold_iss >= 0) chk("credit_issues", hold_iss, v.exp_hold_iss);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int iss, last, vcyc, nd;
        //            op     len scal      v0        vn        step bub hold exp       hold_iss
        tbl[0]  = '{2'd0, 4, 16'h0000, 16'h5800, 16'h5800, 0, 1'b0, 0,  16'h6000, -1};
        tbl[1]  = '{2'd0, 3, 16'h0000, 16'h4400, 16'hBC00, 0, 1'b1, 0,  16'h4000, -1};
        tbl[2]  = '{2'd0, 2, 16'h0000, 16'h3C00, 16'h1000, 0, 1'b0, 0,  16'h3C00, -1};
        tbl[3]  = '{2'd0, 3, 16'h0000, 16'h3C01, 16'h1000, 0, 1'b0, 0,  16'h3C02, -1};
        tbl[4]  = '{2'd0, 0, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0, 0,  16'h0000, -1};
        tbl[5]  = '{2'd2, 3, 16'h4000, 16'h4000, 16'h0000, 0, 1'b0, 20, 16'h0000, 3};
        tbl[6]  = '{2'd1, 0, 16'h1234, 16'h0000, 16'h0000, 0, 1'b0, 0,  16'h0000, -1};
        tbl[7]  = '{2'd1, 5, 16'h0000, 16'h1234, 16'h0000, 1, 1'b1, 0,  16'h0000, -1};
        tbl[8]  = '{2'd2, 5, 16'h3800, 16'h2000, 16'h0000, 3, 1'b0, 10, 16'h0000, 3};
        tbl[9]  = '{2'd3, 2, 16'h0000, 16'h7000, 16'h0000, 1, 1'b0, 0,  16'h0000, -1};
        tbl[10] = '{2'd0, 1, 16'h0000, 16'h4500, 16'h0000, 0, 1'b0, 3,  16'h4500, -1};
        tbl[11] = '{2'd0, 4, 16'h0000, 16'hC000, 16'h3C00, 0, 1'b0, 0,  16'h3C00, -1};

        tile_now = 16'hDEAD;
        tile_now0 = 16'h5800;
        bif.cmd_valid_i = 1'b0; bif.cmd_op_i = '0; bif.cmd_len_i = '0; bif.cmd_scal_i = '0;
        bif.op_valid_i = 1'b0; bif.res_vec_ready_i = 1'b0; bif.res_scal_ready_i = 1'b0;
        bif0.cmd_valid_i = 1'b0; bif0.cmd_op_i = '0; bif0.cmd_len_i = '0; bif0.cmd_scal_i = '0;
        bif0.op_valid_i = 1'b0; bif0.res_vec_ready_i = 1'b0; bif0.res_scal_ready_i = 1'b0;

        #3 rst = 1'b1;
        #1;
        chk("rst_cmd_ready", bif.cmd_ready_o, 1);
        chk("rst_op_ready", bif.op_ready_o, 0);
        chk("rst_busy", bif.busy_o, 0);
        chk("rst_done", bif.done_o, 0);
        chk("rst_res_scal", bif.res_scal_o, 0);
        chk("rst_res_vec_valid", bif.res_vec_valid_o, 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 12; i++) run_cmd(tbl[i]);

        // Asynchronous reset in the middle of an EWMUL with results buffered.
        for (int k = 0; k < 20 && bif.cmd_ready_o !== 1'b1; k++) begin
            @(posedge clk); #1;
        end
        bif.res_vec_ready_i = 1'b0;
        bif.cmd_valid_i = 1'b1; bif.cmd_op_i = 2'd1; bif.cmd_len_i = 8'd5; bif.cmd_scal_i = 16'h5555;
        @(posedge clk); #1;
        bif.cmd_valid_i = 1'b0;
        iss = 0;
        for (int k = 0; k < 20 && iss < 2; k++) begin
            bif.op_valid_i = 1'b1;
            tile_now = 16'h1111;
            @(negedge clk);
            if (bif.op_ready_o) iss++;
            @(posedge clk); #1;
        end
        bif.op_valid_i = 1'b0;
        tile_now = 16'hDEAD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("pre_rst_vec_valid", bif.res_vec_valid_o, 1);
        chk("pre_rst_busy", bif.busy_o, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_cmd_ready", bif.cmd_ready_o, 1);
        chk("mid_rst_op_ready", bif.op_ready_o, 0);
        chk("mid_rst_busy", bif.busy_o, 0);
        chk("mid_rst_vec_valid", bif.res_vec_valid_o, 0);
        chk("mid_rst_vec_data", bif.res_vec_o[31:0], 0);
        chk("mid_rst_res_scal", bif.res_scal_o, 0);
        chk("mid_rst_tile_scal", bif.tile_scal_o, 0);
        chk("mid_rst_done", bif.done_o, 0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        #1;
        chk("post_rst_done", bif.done_o, 0);
        @(posedge clk); #1;
        run_cmd(tbl[0]);

        // Zero-latency instance: four all-ones chunks, one chunk per cycle.
        bif0.cmd_valid_i = 1'b1; bif0.cmd_op_i = 2'd0; bif0.cmd_len_i = 8'd4;
        @(negedge clk);
        chk("l0_cmd_ready", bif0.cmd_ready_o, 1);
        @(posedge clk); #1;
        bif0.cmd_valid_i = 1'b0;
        iss = 0; last = -1; vcyc = -1; nd = 0;
        for (int c = 0; c < 40 && nd == 0; c++) begin
            bif0.op_valid_i = (iss < 4);
            bif0.res_scal_ready_i = 1'b1;
            @(negedge clk);
            if (bif0.op_valid_i && bif0.op_ready_o) begin
                iss++;
                last = c;
            end
            if (bif0.res_scal_valid_o && vcyc < 0) begin
                vcyc = c;
                chk("l0_scal_result", bif0.res_scal_o, 16'h6000);
            end
            if (bif0.done_o) nd++;
            @(posedge clk); #1;
        end
        bif0.op_valid_i = 1'b0;
        chk("l0_last_issue", last, 3);
        chk("l0_scal_vld_time", vcyc, 4);
        chk("l0_done_count", nd, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
